mem_bist_ctrl: RTL

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_pkg.sv | 21 ++
 rtl/mem_bist_if.sv | 28 ++
 rtl/mem_bist_addr_gen.sv | 29 ++
 rtl/mem_bist_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and the test-pattern rule for the memory BIST controller.
// Pass 0 writes each word with its own address; pass 1 writes the bitwise inverse.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } bist_state_t;

    localparam int PAT_MAX_W = 32;

    // Callers size-cast the result down to their word width (at most PAT_MAX_W bits).
    function automatic logic [PAT_MAX_W-1:0] bist_pattern(input logic [PAT_MAX_W-1:0] addr,
                                                          input logic                 pass_idx);
        return pass_idx ? ~addr : addr;
    endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Memory-side bus driven by the BIST controller (master) into the memory (slave).
// data_out is a registered read: valid the cycle after read was high.
interface mem_bist_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output read,
        output write,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/mem_bist_addr_gen.sv
// Address counter for the BIST sweep: clear beats load beats enable, no wrap guard.
// o_tc flags the last address so the controller can stop before the counter wraps.
module mem_bist_addr_gen #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_val,
    output logic [ADDR_WIDTH-1:0] o_cnt,
    output logic                  o_tc
);
    logic [ADDR_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = &r_cnt;
endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style BIST: write a pattern sweep, read it back, count miscompares; done 2*DEPTH+2 after start.
// Define MEM_BIST_INV_PASS_EN to add a second, inverted-pattern pass (done at 4*DEPTH+4).
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    mem_bist_if.master            mem,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH+1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);
    bist_state_t           r_state;
    logic                  r_launch;
    logic                  r_read;
    logic                  r_write;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_fail;
    logic                  r_cmp_vld;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [ADDR_WIDTH+1:0] r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_first_err_addr;

    logic [ADDR_WIDTH-1:0] w_cnt;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_pat;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_tc;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic                  w_accept;
    logic                  w_sweep;
    logic                  w_miscmp;
    logic                  w_pass;

`ifdef MEM_BIST_INV_PASS_EN
    logic r_pass;
    assign w_pass = r_pass;
`else
    assign w_pass = 1'b0;
`endif

    // A start is taken once, then the launch cycle in IDLE kicks off the write sweep.
    assign w_accept  = start && !r_launch && (r_state == IDLE || r_state == DONE);
    assign w_sweep   = (r_state == WR) || (r_state == RD);
    assign w_cnt_en  = w_sweep && !w_tc;
    assign w_cnt_clr = w_accept || (w_sweep && w_tc);

    assign w_wr_addr = (r_state == WR) ? w_cnt + ADDR_WIDTH'(1) : '0;
    assign w_wr_pat  = DATA_WIDTH'(bist_pattern(32'(w_wr_addr), w_pass));
    assign w_exp     = DATA_WIDTH'(bist_pattern(32'(r_cmp_addr), w_pass));
    assign w_miscmp  = r_cmp_vld && (mem.data_out != w_exp);

    mem_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_launch         <= 1'b0;
            r_read           <= 1'b0;
            r_write          <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_fail           <= 1'b0;
            r_cmp_vld        <= 1'b0;
            r_cmp_addr       <= '0;
            r_data_in        <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
`ifdef MEM_BIST_INV_PASS_EN
            r_pass           <= 1'b0;
`endif
        end else begin
            if (w_miscmp) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_first_err_addr <= r_cmp_addr;
                end
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end

            if (w_accept) begin
                r_state          <= IDLE;
                r_launch         <= 1'b1;
                r_busy           <= 1'b1;
                r_done           <= 1'b0;
                r_fail           <= 1'b0;
                r_err_cnt        <= '0;
                r_first_err_addr <= '0;
`ifdef MEM_BIST_INV_PASS_EN
                r_pass           <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_launch) begin
                            r_state   <= WR;
                            r_launch  <= 1'b0;
                            r_write   <= 1'b1;
                            r_data_in <= w_wr_pat;
                        end
                    end
                    WR: begin
                        r_data_in <= w_wr_pat;
                        if (w_tc) begin
                            r_state   <= RD;
                            r_write   <= 1'b0;
                            r_read    <= 1'b1;
                            r_data_in <= '0;
                        end
                    end
                    RD: begin
                        // Read data returns next cycle, so remember which address it belongs to.
                        r_cmp_vld  <= 1'b1;
                        r_cmp_addr <= w_cnt;
                        if (w_tc) begin
                            r_state <= DRAIN;
                            r_read  <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        r_cmp_vld <= 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
                        if (!r_pass) begin
                            r_pass   <= 1'b1;
                            r_launch <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
`else
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mem.read       = r_read;
    assign mem.write      = r_write;
    assign mem.addr       = w_cnt;
    assign mem.data_in    = r_data_in;
    assign busy           = r_busy;
    assign done           = r_done;
    assign fail           = r_fail;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
endmodule
